// File: rtl/mux_8x4_collect.sv
// mux_8x4_collect: round-robin collector of eight 4-bit lanes onto one
// (value, lane index) stream with a valid/ready output handshake.

// One lane: a single-entry holding buffer with a one-cycle capture ack.
module mux_8x4_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             req,
    input  logic             grant,
    output logic [WIDTH-1:0] hold,
    output logic             pending,
    output logic             ack
);
    logic capture;

    // A request is ignored while the buffer is full or the ack is still out.
    assign capture = req & ~pending & ~ack;

    // Capture loads the buffer; a grant empties it (never both in one cycle).
    always_ff @(posedge clk) begin
        if (reset) begin
            hold    <= '0;
            pending <= 1'b0;
            ack     <= 1'b0;
        end else begin
            ack <= capture;
            if (capture) begin
                hold    <= d;
                pending <= 1'b1;
            end else if (grant) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

module mux_8x4_collect #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] D [7:0],
    input  logic [7:0]       req,
    output logic [7:0]       ack,
    output logic [WIDTH-1:0] out_val,
    output logic [2:0]       out_sel,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] hold [8];
    logic [7:0]       pending;
    logic [7:0]       grant_vec;
    logic [2:0]       ptr;
    logic [2:0]       gnt;
    logic [2:0]       idx;
    logic             found;
    logic             free;

    for (genvar i = 0; i < 8; i++) begin : g_lane
        mux_8x4_lane #(.WIDTH(WIDTH)) u_lane (
            .clk     (clk),
            .reset   (reset),
            .d       (D[i]),
            .req     (req[i]),
            .grant   (grant_vec[i]),
            .hold    (hold[i]),
            .pending (pending[i]),
            .ack     (ack[i])
        );
    end

    // Output slot can take a new entry when empty or being drained now.
    assign free = ~out_valid | out_ready;

    // First pending lane at or after ptr, wrapping modulo 8.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && pending[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    assign grant_vec = (free && found) ? (8'd1 << gnt) : 8'd0;

    // Output register and round-robin pointer; value/sel hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_val   <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
        end else if (free) begin
            if (found) begin
                out_val   <= hold[gnt];
                out_sel   <= gnt;
                out_valid <= 1'b1;
                ptr       <= gnt + 3'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mux_8x4_collect.sv
// Bench for mux_8x4_collect: vector table, directed corner sequences and a
// random run, all compared against a per-edge reference model.
module tb_mux_8x4_collect;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] D [7:0];
    logic [7:0] req;
    logic [7:0] ack;
    logic [3:0] out_val;
    logic [2:0] out_sel;
    logic       out_valid;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    mux_8x4_collect #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .D         (D),
        .req       (req),
        .ack       (ack),
        .out_val   (out_val),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference model state: what the block should hold after each edge.
    bit [3:0] m_hold [8];
    bit [7:0] m_pend;
    bit [7:0] m_ack;
    int       m_ptr;
    bit [3:0] m_val;
    int       m_sel;
    bit       m_vld;

    typedef struct {
        bit        rst;
        bit [31:0] d;
        bit [7:0]  rq;
        bit        rdy;
        bit [7:0]  e_ack;
        bit        e_vld;
        bit [2:0]  e_sel;
        bit [3:0]  e_val;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the rules of one clock edge to the model using current inputs.
    task automatic model_edge();
        bit [7:0] cap;
        int       g;
        bit       fr;
        if (reset) begin
            foreach (m_hold[i]) m_hold[i] = 4'h0;
            m_pend = 0; m_ack = 0; m_ptr = 0;
            m_val = 0; m_sel = 0; m_vld = 0;
            return;
        end
        fr  = !m_vld || out_ready;
        g   = -1;
        cap = req & ~m_pend & ~m_ack;
        if (fr) begin
            for (int k = 0; k < 8; k++)
                if (g < 0 && m_pend[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
            if (g >= 0) begin
                m_val     = m_hold[g];
                m_sel     = g;
                m_vld     = 1'b1;
                m_pend[g] = 1'b0;
                m_ptr     = (g + 1) % 8;
            end else begin
                m_vld = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++)
            if (cap[i]) begin
                m_hold[i] = D[i];
                m_pend[i] = 1'b1;
            end
        m_ack = cap;
    endtask

    // One clock: model steps at the edge, outputs compared 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_ack", 32'(ack), 32'(m_ack));
        chk("model_valid", 32'(out_valid), 32'(m_vld));
        chk("model_sel", 32'(out_sel), 32'(m_sel));
        chk("model_val", 32'(out_val), 32'(m_val));
    endtask

    task automatic set_d(input bit [31:0] d);
        for (int i = 0; i < 8; i++) D[i] = d[i*4 +: 4];
    endtask

    task automatic do_reset();
        reset = 1'b1; req = 8'h00; tick(); reset = 1'b0;
    endtask

    function automatic vec_t mk(bit rst, bit [31:0] d, bit [7:0] rq, bit rdy,
                                bit [7:0] ea, bit ev, bit [2:0] es, bit [3:0] eval);
        vec_t v;
        v.rst = rst; v.d = d; v.rq = rq; v.rdy = rdy;
        v.e_ack = ea; v.e_vld = ev; v.e_sel = es; v.e_val = eval;
        return v;
    endfunction

    initial begin
        reset = 1'b1; req = 8'h00; out_ready = 1'b0; set_d(32'h0);

        // Reset with random lane activity, then single lane 5, then all lanes.
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(1, $urandom, 8'($urandom), 1'($urandom), 8'h00, 0, 3'd0, 4'h0));
        tbl.push_back(mk(0, 32'h00A0_0000, 8'h20, 1, 8'h20, 0, 3'd0, 4'h0));
        tbl.push_back(mk(0, 32'h00A0_0000, 8'h00, 1, 8'h00, 1, 3'd5, 4'hA));
        tbl.push_back(mk(0, 32'h00A0_0000, 8'h00, 1, 8'h00, 0, 3'd5, 4'hA));
        tbl.push_back(mk(1, 32'hFEDC_BA98, 8'h00, 1, 8'h00, 0, 3'd0, 4'h0));
        tbl.push_back(mk(0, 32'hFEDC_BA98, 8'hFF, 1, 8'hFF, 0, 3'd0, 4'h0));
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 32'hFEDC_BA98, 8'h00, 1, 8'h00, 1, 3'(k), 4'(8 + k)));
        tbl.push_back(mk(0, 32'hFEDC_BA98, 8'h00, 1, 8'h00, 0, 3'd7, 4'hF));

        @(negedge clk);
        foreach (tbl[n]) begin
            reset = tbl[n].rst; set_d(tbl[n].d); req = tbl[n].rq; out_ready = tbl[n].rdy;
            tick();
            chk($sformatf("tbl%0d_ack", n), 32'(ack), 32'(tbl[n].e_ack));
            chk($sformatf("tbl%0d_valid", n), 32'(out_valid), 32'(tbl[n].e_vld));
            chk($sformatf("tbl%0d_sel", n), 32'(out_sel), 32'(tbl[n].e_sel));
            chk($sformatf("tbl%0d_val", n), 32'(out_val), 32'(tbl[n].e_val));
        end
        reset = 1'b0;

        // Backpressure: lanes 1 and 3 pending, consumer stalls 4 cycles.
        do_reset();
        set_d(32'h0000_C030); out_ready = 1'b0; req = 8'h0A; tick();
        req = 8'h00; tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_stall_valid", 32'(out_valid), 32'd1);
            chk("bp_stall_sel", 32'(out_sel), 32'd1);
            chk("bp_stall_val", 32'(out_val), 32'h3);
        end
        out_ready = 1'b1; tick();
        chk("bp_next_sel", 32'(out_sel), 32'd3);
        chk("bp_next_val", 32'(out_val), 32'hC);
        tick();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // Wrap-around: lane 6 first, then 7 beats 2, then ptr must sit at 3.
        do_reset();
        set_d(32'h7600_0320); req = 8'h40; tick();
        req = 8'h00; tick();
        chk("wrap_first", 32'(out_sel), 32'd6);
        tick();
        req = 8'h84; tick();
        req = 8'h00; tick();
        chk("wrap_7", 32'(out_sel), 32'd7);
        tick();
        chk("wrap_2", 32'(out_sel), 32'd2);
        tick();
        chk("wrap_idle", 32'(out_valid), 32'd0);
        req = 8'h0C; tick();
        req = 8'h00; tick();
        chk("wrap_ptr3", 32'(out_sel), 32'd3);
        tick(); tick();

        // Re-request: req[4] held high; ack pattern 1,0,1,0 with recapture.
        do_reset();
        set_d(32'h0009_0000); out_ready = 1'b1; req = 8'h10; tick();
        chk("rr_ack1", 32'(ack), 32'h10);
        set_d(32'h0005_0000); tick();
        chk("rr_noack", 32'(ack), 32'h00);
        chk("rr_grant_val", 32'(out_val), 32'h9);
        tick();
        chk("rr_recap", 32'(ack), 32'h10);
        req = 8'h00; out_ready = 1'b0; tick();
        chk("rr_second_val", 32'(out_val), 32'h5);
        chk("rr_second_sel", 32'(out_sel), 32'd4);
        req = 8'h07; tick();
        req = 8'h00; tick();
        reset = 1'b1; tick();
        reset = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rst_mid_valid", 32'(out_valid), 32'd0);
            chk("rst_mid_ack", 32'(ack), 32'd0);
        end

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            req       = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 8; i++) D[i] = 4'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
